uart_channel_arbiter: RTL

- Shares one uart_comm byte link between 2^CHANNEL_BIT on-chip requesters, e.g. CPU debug port, memory loader and I/O console.
- Transmit: round-robin arbitration; each granted message is framed as a header byte (channel id) followed by MSG_BYTES payload bytes.
- Receive: parses the same framing and delivers each complete message to the addressed channel.
- Sits directly on uart_comm's FIFO-side flag/data/sendable/receivable interface.

---
 rtl/uart_channel_arbiter_if.sv | 39 +++
 rtl/uart_channel_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_channel_arbiter_if.sv
// Bus bundle for uart_channel_arbiter: requester side (send/recv) plus the
// FIFO-side flag/data/sendable/receivable handshake of uart_comm.
// master = the arbiter itself, slave = the environment driving it.
interface uart_channel_arbiter_if #(
    parameter int CHANNEL_BIT = 2,
    parameter int MSG_BYTES   = 4
);
    localparam int NCH   = 1 << CHANNEL_BIT;
    localparam int MSG_W = MSG_BYTES * 8;

    // requester side
    logic [NCH-1:0]         send_req;
    logic [NCH*MSG_W-1:0]   send_msg;
    logic [NCH-1:0]         send_done;
    logic                   recv_valid;
    logic [CHANNEL_BIT-1:0] recv_chan;
    logic [MSG_W-1:0]       recv_msg;
    logic                   recv_err;

    // uart_comm FIFO side
    logic                   uart_send_flag;
    logic [7:0]             uart_send_data;
    logic                   uart_sendable;
    logic                   uart_recv_flag;
    logic [7:0]             uart_recv_data;
    logic                   uart_receivable;

    modport master (
        input  send_req, send_msg, uart_sendable, uart_recv_data, uart_receivable,
        output send_done, recv_valid, recv_chan, recv_msg, recv_err,
               uart_send_flag, uart_send_data, uart_recv_flag
    );

    modport slave (
        output send_req, send_msg, uart_sendable, uart_recv_data, uart_receivable,
        input  send_done, recv_valid, recv_chan, recv_msg, recv_err,
               uart_send_flag, uart_send_data, uart_recv_flag
    );
endinterface

// File: rtl/uart_channel_arbiter.sv
// uart_channel_arbiter: shares one uart_comm byte link between 2^CHANNEL_BIT
// requesters. TX side arbitrates round-robin and frames each message as
// header (channel id) + MSG_BYTES payload bytes; RX side parses the same
// framing and delivers complete messages tagged with their channel.
// Optional macro UART_ARB_CHECKSUM_EN appends/checks an XOR checksum byte
// covering header and payload.
module uart_channel_arbiter #(
    parameter int CHANNEL_BIT = 2,
    parameter int MSG_BYTES   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_channel_arbiter_if.master bus
);
    localparam int NCH   = 1 << CHANNEL_BIT;
    localparam int MSG_W = MSG_BYTES * 8;
    localparam int CNT_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_BYTES - 1);

    typedef enum logic [2:0] {
        T_IDLE,
        T_HEAD,
        T_BODY,
`ifdef UART_ARB_CHECKSUM_EN
        T_SUM,
`endif
        T_DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        R_HEAD,
        R_BODY
`ifdef UART_ARB_CHECKSUM_EN
        , R_SUM
`endif
    } rx_state_t;

    // ------------------------------------------------------------------
    // TX side
    // ------------------------------------------------------------------
    tx_state_t              r_tx_state;
    tx_state_t              w_tx_state_next;
    logic [CHANNEL_BIT-1:0] r_tx_chan;
    logic [CHANNEL_BIT-1:0] w_tx_chan_next;
    logic [CHANNEL_BIT-1:0] r_last;
    logic [CHANNEL_BIT-1:0] w_last_next;
    logic [MSG_W-1:0]       r_tx_msg;
    logic [MSG_W-1:0]       w_tx_msg_next;
    logic [CNT_W-1:0]       r_tx_cnt;
    logic [CNT_W-1:0]       w_tx_cnt_next;
`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0]             r_tx_sum;
    logic [7:0]             w_tx_sum_next;
`endif

    logic [MSG_W-1:0]       w_req_msg [NCH];
    logic [NCH-1:0]         w_rot_req;
    logic                   w_any_req;
    logic [CHANNEL_BIT-1:0] w_grant_off;
    logic [CHANNEL_BIT-1:0] w_grant_chan;
    logic [7:0]             w_tx_bytes [MSG_BYTES];
    logic [7:0]             w_tx_byte;
    logic [7:0]             w_head_byte;
    logic                   w_send_flag;
    logic [7:0]             w_send_data;
    logic [NCH-1:0]         w_send_done;

    genvar gi;

    // Split the flat request payload bus into one word per channel.
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_req_msg
            assign w_req_msg[gi] = bus.send_msg[gi*MSG_W +: MSG_W];
        end
    endgenerate

    // Requests rotated so bit 0 is the channel right after the last grant;
    // the index wraps naturally because it is CHANNEL_BIT wide.
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_rot_req
            logic [CHANNEL_BIT-1:0] w_idx;
            assign w_idx         = r_last + CHANNEL_BIT'(gi + 1);
            assign w_rot_req[gi] = bus.send_req[w_idx];
        end
    endgenerate

    // Latched payload viewed as bytes, byte 0 in the LSBs.
    generate
        for (gi = 0; gi < MSG_BYTES; gi++) begin : g_tx_bytes
            assign w_tx_bytes[gi] = r_tx_msg[gi*8 +: 8];
        end
    endgenerate

    // First set bit of the rotated request vector wins the grant.
    always_comb begin
        w_any_req   = |w_rot_req;
        w_grant_off = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_rot_req[i]) begin
                w_grant_off = CHANNEL_BIT'(i);
            end
        end
    end

    assign w_grant_chan = r_last + w_grant_off + CHANNEL_BIT'(1);
    assign w_tx_byte    = w_tx_bytes[r_tx_cnt];
    assign w_head_byte  = {{(8 - CHANNEL_BIT){1'b0}}, r_tx_chan};

    // TX next-state and UART write-side outputs.
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_chan_next  = r_tx_chan;
        w_last_next     = r_last;
        w_tx_msg_next   = r_tx_msg;
        w_tx_cnt_next   = r_tx_cnt;
`ifdef UART_ARB_CHECKSUM_EN
        w_tx_sum_next   = r_tx_sum;
`endif
        w_send_flag     = 1'b0;
        w_send_data     = 8'h00;
        w_send_done     = '0;

        case (r_tx_state)
            T_IDLE: begin
                if (w_any_req) begin
                    w_tx_chan_next  = w_grant_chan;
                    w_last_next     = w_grant_chan;
                    w_tx_msg_next   = w_req_msg[w_grant_chan];
                    w_tx_state_next = T_HEAD;
                end
            end
            T_HEAD: begin
                w_send_flag = bus.uart_sendable;
                w_send_data = w_head_byte;
                if (bus.uart_sendable) begin
                    w_tx_cnt_next   = '0;
`ifdef UART_ARB_CHECKSUM_EN
                    w_tx_sum_next   = w_head_byte;
`endif
                    w_tx_state_next = T_BODY;
                end
            end
            T_BODY: begin
                w_send_flag = bus.uart_sendable;
                w_send_data = w_tx_byte;
                if (bus.uart_sendable) begin
`ifdef UART_ARB_CHECKSUM_EN
                    w_tx_sum_next = r_tx_sum ^ w_tx_byte;
`endif
                    if (r_tx_cnt == LAST_IDX) begin
`ifdef UART_ARB_CHECKSUM_EN
                        w_tx_state_next = T_SUM;
`else
                        w_tx_state_next = T_DONE;
`endif
                    end else begin
                        w_tx_cnt_next = r_tx_cnt + CNT_W'(1);
                    end
                end
            end
`ifdef UART_ARB_CHECKSUM_EN
            T_SUM: begin
                w_send_flag = bus.uart_sendable;
                w_send_data = r_tx_sum;
                if (bus.uart_sendable) begin
                    w_tx_state_next = T_DONE;
                end
            end
`endif
            T_DONE: begin
                w_send_done     = NCH'(1) << r_tx_chan;
                w_tx_state_next = T_IDLE;
            end
            default: begin
                w_tx_state_next = T_IDLE;
            end
        endcase
    end

    // TX state register; last starts at NCH-1 so channel 0 is granted first.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_state <= T_IDLE;
            r_tx_chan  <= '0;
            r_last     <= CHANNEL_BIT'(NCH - 1);
            r_tx_msg   <= '0;
            r_tx_cnt   <= '0;
`ifdef UART_ARB_CHECKSUM_EN
            r_tx_sum   <= 8'h00;
`endif
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_chan  <= w_tx_chan_next;
            r_last     <= w_last_next;
            r_tx_msg   <= w_tx_msg_next;
            r_tx_cnt   <= w_tx_cnt_next;
`ifdef UART_ARB_CHECKSUM_EN
            r_tx_sum   <= w_tx_sum_next;
`endif
        end
    end

    assign bus.uart_send_flag = w_send_flag;
    assign bus.uart_send_data = w_send_data;
    assign bus.send_done      = w_send_done;

    // ------------------------------------------------------------------
    // RX side
    // ------------------------------------------------------------------
    rx_state_t              r_rx_state;
    rx_state_t              w_rx_state_next;
    logic [CHANNEL_BIT-1:0] r_rx_chan;
    logic [CHANNEL_BIT-1:0] w_rx_chan_next;
    logic [CNT_W-1:0]       r_rx_cnt;
    logic [CNT_W-1:0]       w_rx_cnt_next;
    logic [MSG_W-1:0]       r_rx_buf;
    logic [MSG_W-1:0]       w_rx_buf_next;
`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0]             r_rx_sum;
    logic [7:0]             w_rx_sum_next;
`endif
    logic                   r_recv_valid;
    logic                   w_recv_valid_next;
    logic                   r_recv_err;
    logic                   w_recv_err_next;
    logic [CHANNEL_BIT-1:0] r_recv_chan;
    logic [CHANNEL_BIT-1:0] w_recv_chan_next;
    logic [MSG_W-1:0]       r_recv_msg;
    logic [MSG_W-1:0]       w_recv_msg_next;
    logic                   w_pop;
    logic [7:0]             w_rx_data;

    // No backpressure: every byte at the FIFO head is popped immediately.
    assign w_pop     = bus.uart_receivable;
    assign w_rx_data = bus.uart_recv_data;

    // RX next-state: one parser step per popped byte.
    always_comb begin
        w_rx_state_next   = r_rx_state;
        w_rx_chan_next    = r_rx_chan;
        w_rx_cnt_next     = r_rx_cnt;
        w_rx_buf_next     = r_rx_buf;
`ifdef UART_ARB_CHECKSUM_EN
        w_rx_sum_next     = r_rx_sum;
`endif
        w_recv_valid_next = 1'b0;
        w_recv_err_next   = 1'b0;
        w_recv_chan_next  = r_recv_chan;
        w_recv_msg_next   = r_recv_msg;

        if (w_pop) begin
            case (r_rx_state)
                R_HEAD: begin
                    // Anything above the channel field is not a header; drop it
                    // and try again on the next byte.
                    if (w_rx_data[7:CHANNEL_BIT] == '0) begin
                        w_rx_chan_next  = w_rx_data[CHANNEL_BIT-1:0];
                        w_rx_cnt_next   = '0;
`ifdef UART_ARB_CHECKSUM_EN
                        w_rx_sum_next   = w_rx_data;
`endif
                        w_rx_state_next = R_BODY;
                    end else begin
                        w_recv_err_next = 1'b1;
                    end
                end
                R_BODY: begin
                    w_rx_buf_next[r_rx_cnt*8 +: 8] = w_rx_data;
`ifdef UART_ARB_CHECKSUM_EN
                    w_rx_sum_next = r_rx_sum ^ w_rx_data;
`endif
                    if (r_rx_cnt == LAST_IDX) begin
`ifdef UART_ARB_CHECKSUM_EN
                        w_rx_state_next   = R_SUM;
`else
                        w_recv_valid_next = 1'b1;
                        w_recv_chan_next  = r_rx_chan;
                        w_recv_msg_next   = w_rx_buf_next;
                        w_rx_state_next   = R_HEAD;
`endif
                    end else begin
                        w_rx_cnt_next = r_rx_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_ARB_CHECKSUM_EN
                R_SUM: begin
                    if (w_rx_data == r_rx_sum) begin
                        w_recv_valid_next = 1'b1;
                        w_recv_chan_next  = r_rx_chan;
                        w_recv_msg_next   = r_rx_buf;
                    end else begin
                        w_recv_err_next   = 1'b1;
                    end
                    w_rx_state_next = R_HEAD;
                end
`endif
                default: begin
                    w_rx_state_next = R_HEAD;
                end
            endcase
        end
    end

    // RX state and registered delivery outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_state   <= R_HEAD;
            r_rx_chan    <= '0;
            r_rx_cnt     <= '0;
            r_rx_buf     <= '0;
`ifdef UART_ARB_CHECKSUM_EN
            r_rx_sum     <= 8'h00;
`endif
            r_recv_valid <= 1'b0;
            r_recv_err   <= 1'b0;
            r_recv_chan  <= '0;
            r_recv_msg   <= '0;
        end else begin
            r_rx_state   <= w_rx_state_next;
            r_rx_chan    <= w_rx_chan_next;
            r_rx_cnt     <= w_rx_cnt_next;
            r_rx_buf     <= w_rx_buf_next;
`ifdef UART_ARB_CHECKSUM_EN
            r_rx_sum     <= w_rx_sum_next;
`endif
            r_recv_valid <= w_recv_valid_next;
            r_recv_err   <= w_recv_err_next;
            r_recv_chan  <= w_recv_chan_next;
            r_recv_msg   <= w_recv_msg_next;
        end
    end

    assign bus.uart_recv_flag = w_pop;
    assign bus.recv_valid     = r_recv_valid;
    assign bus.recv_err       = r_recv_err;
    assign bus.recv_chan      = r_recv_chan;
    assign bus.recv_msg       = r_recv_msg;

endmodule
